// File: rtl/saber_mul_pkg.sv
// Shared constants for the Saber schoolbook multiplier datapath.
package saber_mul_pkg;
    localparam int N            = 256;
    localparam int QW           = 13;
    localparam int SW           = 4;
    localparam int SEC_WORDS    = 16;
    localparam int BUF_W        = 676;
    localparam int GROUP_LOADS  = 12;
    localparam int GROUP_STRIDE = 51;
endpackage

// File: rtl/mac13_sm4.sv
// Single-lane MAC: acc +/- a*|s| mod 2^QW with a sign-magnitude secret.
module mac13_sm4 #(
    parameter int QW = 13,
    parameter int SW = 4
) (
    input  logic [QW-1:0] a,
    input  logic [SW-1:0] s,
    input  logic [QW-1:0] acc,
    output logic [QW-1:0] res
);
    localparam int PW = QW + SW - 1;

    logic [PW-1:0] prod;
    logic [PW-1:0] sum;

    always_comb begin
        prod = PW'(a) * PW'(s[SW-2:0]);
        // Wide add/subtract, truncated afterwards; negative zero falls out as acc - 0.
        if (s[SW-1])
            sum = PW'(acc) - prod;
        else
            sum = PW'(acc) + prod;
        res = sum[QW-1:0];
    end
endmodule

// File: rtl/poly_mul_datapath.sv
// Secret-load sequencer, public-coefficient selector and N-lane MAC array.
module poly_mul_datapath #(
    parameter int N  = saber_mul_pkg::N,
    parameter int QW = saber_mul_pkg::QW,
    parameter int SW = saber_mul_pkg::SW
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [7:0]                    s_address,
    output logic                          s_load,
    output logic                          s_load_done,
    input  logic [saber_mul_pkg::BUF_W-1:0] buffer,
    input  logic [3:0]                    buffer_counter,
    input  logic                          pol_load_coeff4x,
    output logic [QW-1:0]                 a_coeff,
    input  logic [N*QW-1:0]               acc_in,
    input  logic [N*SW-1:0]               secret_in,
    output logic [N*QW-1:0]               result
);
    import saber_mul_pkg::*;

    localparam logic [4:0] C_LAST = 5'(SEC_WORDS + 1);

    logic [4:0] c;
    logic [9:0] sel_lsb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            c <= '0;
        else if (c != C_LAST)
            c <= c + 5'd1;
    end

    // Data from address k returns while c = k+1, so the load window is c = 1..16.
    always_comb begin
        s_address   = (c <= 5'(SEC_WORDS - 1)) ? 8'(c) : 8'(SEC_WORDS - 1);
        s_load      = (c >= 5'd1) && (c <= 5'(SEC_WORDS));
        s_load_done = (c == C_LAST);
    end

    always_comb begin
        sel_lsb = '0;
        if (pol_load_coeff4x)
            sel_lsb = 10'd48;
        else if (int'(buffer_counter) < GROUP_LOADS)
            sel_lsb = 10'(GROUP_STRIDE * (GROUP_LOADS - int'(buffer_counter)));
        a_coeff = buffer[sel_lsb +: QW];
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mac13_sm4 #(
            .QW(QW),
            .SW(SW)
        ) u_mac (
            .a  (a_coeff),
            .s  (secret_in[SW*i +: SW]),
            .acc(acc_in[QW*i +: QW]),
            .res(result[QW*i +: QW])
        );
    end
endmodule

// File: tb/tb_poly_mul_datapath.sv
// Self-checking bench: load sequencer timing, selector modes, MAC vectors and random lanes.
module tb_poly_mul_datapath;
    localparam int N  = 256;
    localparam int QW = 13;
    localparam int SW = 4;
    localparam int BW = 676;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        s_address;
    logic              s_load;
    logic              s_load_done;
    logic [BW-1:0]     buffer = '0;
    logic [3:0]        buffer_counter = '0;
    logic              pol_load_coeff4x = 1'b0;
    logic [QW-1:0]     a_coeff;
    logic [N*QW-1:0]   acc_in = '0;
    logic [N*SW-1:0]   secret_in = '0;
    logic [N*QW-1:0]   result;

    int total = 0;
    int bad   = 0;

    poly_mul_datapath #(.N(N), .QW(QW), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .s_address(s_address), .s_load(s_load), .s_load_done(s_load_done),
        .buffer(buffer), .buffer_counter(buffer_counter), .pol_load_coeff4x(pol_load_coeff4x),
        .a_coeff(a_coeff), .acc_in(acc_in), .secret_in(secret_in), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned acc;
        logic [3:0]  s;
        int unsigned a;
        int unsigned exp;
    } mac_vec_t;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected sequencer outputs n cycles after reset release.
    task automatic chk_seq(input string tag, input int n);
        int cc;
        cc = (n > 17) ? 17 : n;
        chk({tag, " s_address"}, s_address, (cc <= 15) ? cc : 15);
        chk({tag, " s_load"}, s_load, (cc >= 1 && cc <= 16) ? 1 : 0);
        chk({tag, " s_load_done"}, s_load_done, (cc == 17) ? 1 : 0);
    endtask

    function automatic int unsigned ref_a(input logic [BW-1:0] b, input int k, input bit mode);
        logic [BW-1:0] t;
        if (mode)
            t = b >> 48;
        else if (k < 12)
            t = b >> (612 - 51 * k);
        else
            t = b;
        return int'(t & 676'h1FFF);
    endfunction

    function automatic int unsigned ref_lane(input int unsigned acc, input logic [3:0] s, input int unsigned a);
        int v;
        v = int'(acc) + (s[3] ? -1 : 1) * int'(a) * int'(s[2:0]);
        return int'(((v % 8192) + 8192) % 8192);
    endfunction

    initial begin
        mac_vec_t vecs[6];
        logic [703:0] wide;
        logic [BW-1:0] b;
        int unsigned ea;
        int lane_bad;

        vecs[0] = '{acc: 100,  s: 4'b0011, a: 7,    exp: 121};
        vecs[1] = '{acc: 100,  s: 4'b1011, a: 7,    exp: 79};
        vecs[2] = '{acc: 100,  s: 4'b1000, a: 7,    exp: 100};
        vecs[3] = '{acc: 100,  s: 4'b0000, a: 7,    exp: 100};
        vecs[4] = '{acc: 8190, s: 4'b0111, a: 8191, exp: 8183};
        vecs[5] = '{acc: 0,    s: 4'b1001, a: 1,    exp: 8191};

        // Load sequencer from reset.
        @(negedge clk);
        chk_seq("reset", 0);
        rst = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            chk_seq($sformatf("seq c%0d", n), n);
        end

        // Asynchronous reset in the middle of the sequence.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 8; n++) @(negedge clk);
        chk_seq("pre-midreset", 8);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_seq("midreset async", 0);
        @(negedge clk);
        chk_seq("midreset held", 0);
        rst = 1'b1;
        @(negedge clk);
        chk_seq("restart c1", 1);
        @(negedge clk);
        chk_seq("restart c2", 2);

        // Selector, packed 13-bit mode.
        b = '0;
        for (int k = 0; k < 12; k++) b[612 - 51 * k +: 13] = 13'(k + 1);
        b[12:0] = 13'h1ABC;
        buffer = b;
        pol_load_coeff4x = 1'b0;
        for (int k = 0; k < 16; k++) begin
            buffer_counter = 4'(k);
            #1 chk($sformatf("sel13 k%0d", k), a_coeff, (k < 12) ? k + 1 : 32'h1ABC);
        end

        // Selector, four-uint16 mode.
        b = '0;
        b[63:48] = 16'hF123;
        b[12:0] = 13'h0555;
        buffer = b;
        pol_load_coeff4x = 1'b1;
        for (int k = 0; k < 16; k += 5) begin
            buffer_counter = 4'(k);
            #1 chk($sformatf("sel16 k%0d", k), a_coeff, 32'h1123);
        end

        // Directed MAC vectors, each in its own lane; a is driven through 16-bit mode.
        foreach (vecs[v]) begin
            b = '0;
            b[60:48] = 13'(vecs[v].a);
            buffer = b;
            acc_in = '0;
            secret_in = '0;
            acc_in[QW * (v * 37) +: QW] = 13'(vecs[v].acc);
            secret_in[SW * (v * 37) +: SW] = vecs[v].s;
            #1 chk($sformatf("mac vec%0d", v), result[QW * (v * 37) +: QW], vecs[v].exp);
            chk($sformatf("mac vec%0d idle lane", v), result[QW * (v * 37 + 1) +: QW], 0);
        end

        // Random vectors against the per-lane model.
        for (int r = 0; r < 1000; r++) begin
            for (int j = 0; j < 22; j++) wide[32 * j +: 32] = $urandom;
            buffer = wide[BW-1:0];
            for (int j = 0; j < N * QW / 32; j++) acc_in[32 * j +: 32] = $urandom;
            for (int j = 0; j < N * SW / 32; j++) secret_in[32 * j +: 32] = $urandom;
            buffer_counter = 4'($urandom_range(0, 15));
            pol_load_coeff4x = 1'($urandom_range(0, 1));
            ea = ref_a(buffer, int'(buffer_counter), pol_load_coeff4x);
            #1;
            chk($sformatf("rand%0d a_coeff", r), a_coeff, ea);
            lane_bad = -1;
            for (int i = 0; i < N; i++) begin
                if (lane_bad < 0 && int'(result[QW * i +: QW]) != ref_lane(acc_in[QW * i +: QW], secret_in[SW * i +: SW], ea))
                    lane_bad = i;
            end
            if (lane_bad >= 0)
                chk($sformatf("rand%0d lane%0d", r, lane_bad), result[QW * lane_bad +: QW],
                    ref_lane(acc_in[QW * lane_bad +: QW], secret_in[SW * lane_bad +: SW], ea));
            else
                chk($sformatf("rand%0d lanes", r), 0, 0 + (lane_bad < 0 ? 0 : 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poly_mul_datapath.md
# poly_mul_datapath

Arithmetic and control-support datapath for the 256-coefficient Saber schoolbook polynomial multiplier. It bundles three functions:
- a free-running secret-load sequencer that fetches 16 × 64-bit secret words from BRAM after reset;
- a coefficient selector that extracts the current 13-bit public coefficient from the shared 676-bit polynomial buffer;
- a 256-lane combinational multiply-accumulate array that adds `a × s_i` into every accumulator lane.

The enclosing multiplier FSM owns the secret/accumulator registers and the buffer shift control.

## Interface
Parameters:
- `N`, 256, number of coefficients / MAC lanes
- `QW`, 13, accumulator and public-coefficient width (mod 2^13)
- `SW`, 4, secret coefficient width (sign-magnitude)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `s_address`  out  8  BRAM word address of secret; data returns one cycle later
- `s_load`  out  1  high while `s_vec_64` at the parent holds a valid secret word
- `s_load_done`  out  1  secret fully loaded; sticky until reset
- `buffer`  in  676  shared polynomial shift buffer contents
- `buffer_counter`  in  4  index of the 64-bit load within the current 13-bit group
- `pol_load_coeff4x`  in  1  0: packed 13-bit coefficients; 1: four uint16 per word
- `a_coeff`  out  13  selected public coefficient (combinational)
- `acc_in`  in  3328  accumulator, lane i at bits [13i+12:13i]
- `secret_in`  in  1024  secret, coefficient i at bits [4i+3:4i]
- `result`  out  3328  updated accumulator (combinational)

## Operation
Load sequencer:
- 5-bit counter `c`: cleared by reset, increments every cycle, saturates at 17.
- `s_address` = `c` while `c` ≤ 15, otherwise 15; upper address bits are 0.
- `s_load` = 1 for 1 ≤ `c` ≤ 16, i.e. exactly 16 cycles. The word from address k arrives while `c` = k+1.
- `s_load_done` = 1 when `c` = 17.
- The parent shifts each word in at the top of its secret register, so address 0 ends up holding coefficients 0..15.

Coefficient selector, `pol_load_coeff4x` = 0:
- `buffer_counter` k in 0..11 selects `buffer[612−51k+12 : 612−51k]`: k=0 → [624:612], k=11 → [63:51].
- k in 12..15 selects `buffer[12:0]`, the tail drained by 13-bit shifts.

Coefficient selector, `pol_load_coeff4x` = 1:
- `a_coeff` = `buffer[60:48]`, the low 13 bits of the uint16 at [63:48], for every `buffer_counter` value.

MAC array, for each lane i (fully combinational, no registers):
- Inputs: a = `a_coeff`, s = `secret_in[4i+3:4i]`, sign = s[3], mag = s[2:0] (0..7).
- `result_i` = (`acc_in_i` + a·mag) mod 2^13 when sign = 0.
- `result_i` = (`acc_in_i` − a·mag) mod 2^13 when sign = 1.
- Negative zero (4'b1000) leaves the lane unchanged.
- The product is formed at ≥16 bits and truncated to 13 bits after the add/subtract.
- Lanes are independent; there is no carry between lanes.

## Timing
- Reset values: `c` = 0, `s_address` = 0, `s_load` = 0, `s_load_done` = 0.
- Cycle after reset release: `s_address` = 1, `s_load` = 1.
- `s_load_done` rises 17 cycles after reset release and never falls without reset.
- Reset mid-sequence: outputs return to their reset values immediately (asynchronous) and the sequence restarts at address 0.
- `a_coeff` and `result` have zero latency.
  - They must settle within one clock period from changes on `buffer`, `buffer_counter`, `pol_load_coeff4x`, `acc_in` and `secret_in`.
  - The critical path is 13×3 multiply + 13-bit add/subtract.
- No handshake; the parent samples `s_load` and `s_load_done` synchronously.

## Structure
- Shared package `saber_mul_pkg`: `N`, `QW`, `SW`, `SEC_WORDS` = 16, `BUF_W` = 676, `GROUP_LOADS` = 12, `GROUP_STRIDE` = 51.
- One natural sub-module: `mac13_sm4`, a single-lane sign-magnitude MAC, instantiated N times via generate.
- Sequencer and selector are coded inline.

## Test plan
- Load sequence: release reset, log 20 cycles -> `s_address` 0,1,…,15,15,…; `s_load` high on cycles 1–16 only; `s_load_done` high from cycle 17 onward; assert reset at cycle 8 -> all outputs 0 and the sequence restarts.
- Selector, 13-bit mode: set `buffer` = bit pattern with coefficient value k+1 placed at offset 612−51k, and 0x1ABC at [12:0]; sweep `buffer_counter` 0..15 -> `a_coeff` = k+1 for k ≤ 11, 0x1ABC for 12..15.
- Selector, 16-bit mode: `buffer[63:48]` = 16'hF123, `buffer_counter` any value -> `a_coeff` = 13'h1123.
- MAC signs: `acc_in` lane0 = 100, s0 = 4'b0011, a = 7 -> 121; lane1 = 100, s1 = 4'b1011 -> 79; s = 4'b1000 -> 100; s = 0 -> 100.
- MAC wrap: lane = 8190, s = 4'b0111, a = 8191 -> (8190 + 57337) mod 8192 = 8183; lane = 0, s = 4'b1001, a = 1 -> 8191.
- Random: 1000 random `acc_in`/`secret_in`/`a_coeff` vectors versus a golden per-lane model -> all 256 lanes match.
